// File: rtl/ultrasonic_pkg.sv
// Shared types and 50 MHz defaults for the multi-sensor ultrasonic scan controller.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GUARD
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NOECHO  = 2'b01;
    localparam logic [1:0] ST_RANGE   = 2'b10;

    localparam int unsigned DEF_N_SENSOR    = 4;
    localparam int unsigned DEF_TRIG_CYCLES = 500;
    localparam int unsigned DEF_CM_DIV      = 2943;
    localparam int unsigned DEF_WAIT_MAX    = 1_500_000;
    localparam int unsigned DEF_MAX_CM      = 400;
    localparam int unsigned DEF_SLOT_CYCLES = 3_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_ctrl_echo_sync.sv
// Per-channel 2-flop synchronizer with registered single-cycle rise/fall pulses.
module echo_sync_edge #(
    parameter int unsigned W = 4
) (
    input  logic         sys_clk50m,
    input  logic         sys_rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] dly;

    // Pin-to-pulse latency is identical for both edges so widths are preserved.
    always_ff @(posedge sys_clk50m or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            dly   <= sync2;
            rise  <= sync2 & ~dly;
            fall  <= ~sync2 & dly;
        end
    end

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin trigger/echo scheduler sharing one range measurement datapath
// across N_SENSOR ultrasonic rangefinders.
module ultrasonic_scan_ctrl
    import ultrasonic_pkg::*;
#(
    parameter int unsigned N_SENSOR    = DEF_N_SENSOR,
    parameter int unsigned TRIG_CYCLES = DEF_TRIG_CYCLES,
    parameter int unsigned CM_DIV      = DEF_CM_DIV,
    parameter int unsigned WAIT_MAX    = DEF_WAIT_MAX,
    parameter int unsigned MAX_CM      = DEF_MAX_CM,
    parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic                sys_clk50m,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [N_SENSOR-1:0] echo,
    output logic [N_SENSOR-1:0] trig,
    output logic                busy,
    output logic                res_valid,
    output logic [2:0]          res_sel,
    output logic [9:0]          res_dist,
    output logic [1:0]          res_status,
    output logic                frame_done
);

    localparam int unsigned WAIT_W  = $clog2(max_u(TRIG_CYCLES, WAIT_MAX));
    localparam int unsigned PRESC_W = $clog2(CM_DIV);
    localparam int unsigned CM_W    = $clog2(MAX_CM + 2);
    localparam int unsigned SLOT_W  = $clog2(SLOT_CYCLES);
    localparam int unsigned SEL_W   = 3;

    localparam logic [WAIT_W-1:0]  TRIG_LAST  = WAIT_W'(TRIG_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CM_DIV - 1);
    localparam logic [CM_W-1:0]    CM_OVER    = CM_W'(MAX_CM + 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(N_SENSOR - 1);

    state_t              state_q, state_n;
    logic [WAIT_W-1:0]   wait_q, wait_n;
    logic [PRESC_W-1:0]  presc_q, presc_n;
    logic [CM_W-1:0]     cm_q, cm_n;
    logic [SLOT_W-1:0]   slot_q, slot_n;
    logic [SEL_W-1:0]    sel_q, sel_n;

    logic                res_c;
    logic [9:0]          res_dist_c;
    logic [1:0]          res_status_c;

    logic [N_SENSOR-1:0] rise;
    logic [N_SENSOR-1:0] fall;
    logic [N_SENSOR-1:0] sel_oh;
    logic                rise_sel;
    logic                fall_sel;

    echo_sync_edge #(.W(N_SENSOR)) u_sync (
        .sys_clk50m (sys_clk50m),
        .sys_rst    (sys_rst),
        .din        (echo),
        .rise       (rise),
        .fall       (fall)
    );

    // Only the selected channel's edges matter; crosstalk elsewhere is masked.
    assign sel_oh   = N_SENSOR'(1) << sel_q;
    assign rise_sel = |(rise & sel_oh);
    assign fall_sel = |(fall & sel_oh);

    always_ff @(posedge sys_clk50m or negedge sys_rst) begin
        if (!sys_rst) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n      = state_q;
        wait_n       = wait_q;
        presc_n      = presc_q;
        cm_n         = cm_q;
        slot_n       = (slot_q == SLOT_LAST) ? slot_q : slot_q + SLOT_W'(1);
        sel_n        = sel_q;
        res_c        = 1'b0;
        res_dist_c   = '0;
        res_status_c = ST_OK;

        case (state_q)
            S_IDLE: begin
                slot_n = '0;
                wait_n = '0;
                if (enable) state_n = S_TRIG;
            end
            S_TRIG: begin
                wait_n = wait_q + WAIT_W'(1);
                if (wait_q == TRIG_LAST) begin
                    wait_n  = '0;
                    state_n = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (rise_sel) begin
                    // The rise-detect cycle is the first cycle of echo width.
                    presc_n = PRESC_W'(1);
                    cm_n    = '0;
                    state_n = S_MEASURE;
                end else if (wait_q == WAIT_LAST) begin
                    res_c        = 1'b1;
                    res_status_c = ST_NOECHO;
                    state_n      = S_GUARD;
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            S_MEASURE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_n = '0;
                    cm_n    = cm_q + CM_W'(1);
                end else begin
                    presc_n = presc_q + PRESC_W'(1);
                end
                if (cm_q == CM_OVER) begin
                    res_c        = 1'b1;
                    res_status_c = ST_RANGE;
                    res_dist_c   = 10'(MAX_CM);
                    state_n      = S_GUARD;
                end else if (fall_sel) begin
                    res_c        = 1'b1;
                    res_dist_c   = 10'(cm_q);
                    state_n      = S_GUARD;
                end
            end
            S_GUARD: begin
                wait_n = '0;
                if (slot_q == SLOT_LAST) begin
                    slot_n  = '0;
                    sel_n   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                    state_n = enable ? S_TRIG : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk50m or negedge sys_rst) begin
        if (!sys_rst) begin
            wait_q     <= '0;
            presc_q    <= '0;
            cm_q       <= '0;
            slot_q     <= '0;
            sel_q      <= '0;
            trig       <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_sel    <= '0;
            res_dist   <= '0;
            res_status <= ST_OK;
            frame_done <= 1'b0;
        end else begin
            wait_q     <= wait_n;
            presc_q    <= presc_n;
            cm_q       <= cm_n;
            slot_q     <= slot_n;
            sel_q      <= sel_n;
            trig       <= (state_q == S_TRIG) ? sel_oh : '0;
            busy       <= (state_q != S_IDLE);
            res_valid  <= res_c;
            frame_done <= res_c && (sel_q == SEL_LAST);
            if (res_c) begin
                res_sel    <= sel_q;
                res_dist   <= res_dist_c;
                res_status <= res_status_c;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl using scaled-down timing parameters.
module tb_ultrasonic_scan_ctrl;

    localparam int N  = 4;
    localparam int TC = 5;
    localparam int D  = 10;
    localparam int WM = 100;
    localparam int MC = 20;
    localparam int SC = 400;

    logic         sys_clk50m;
    logic         sys_rst;
    logic         enable;
    logic [N-1:0] echo;
    logic [N-1:0] trig;
    logic         busy;
    logic         res_valid;
    logic [2:0]   res_sel;
    logic [9:0]   res_dist;
    logic [1:0]   res_status;
    logic         frame_done;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_rise = 0;
    int n_valid   = 0;
    int n_frame   = 0;

    ultrasonic_scan_ctrl #(
        .N_SENSOR    (N),
        .TRIG_CYCLES (TC),
        .CM_DIV      (D),
        .WAIT_MAX    (WM),
        .MAX_CM      (MC),
        .SLOT_CYCLES (SC)
    ) dut (
        .sys_clk50m (sys_clk50m),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_sel    (res_sel),
        .res_dist   (res_dist),
        .res_status (res_status),
        .frame_done (frame_done)
    );

    initial sys_clk50m = 1'b0;
    always #10 sys_clk50m = ~sys_clk50m;

    always @(posedge sys_clk50m) begin
        cyc <= cyc + 1;
        if (res_valid === 1'b1)  n_valid <= n_valid + 1;
        if (frame_done === 1'b1) n_frame <= n_frame + 1;
    end

    task automatic tick();
        @(posedge sys_clk50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_trig"},       32'(trig),       0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_res_valid"},  32'(res_valid),  0);
        chk({tag, "_res_sel"},    32'(res_sel),    0);
        chk({tag, "_res_dist"},   32'(res_dist),   0);
        chk({tag, "_res_status"}, 32'(res_status), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    // width > 0: echo pulse of that many cycles; 0: no echo; < 0: echo held high.
    task automatic run_slot(input int idx, input int width, input int drop_k,
                            input int exp_dist, input logic [1:0] exp_st, input bit chk_period);
        logic [N-1:0] oh;
        logic [N-1:0] nb;
        int n;
        oh = 4'b0001 << idx;
        nb = 4'b0001 << ((idx + 1) % N);
        n = 0;
        while (trig !== oh && n < 2 * SC) begin tick(); n++; end
        chk("trig_sel", 32'(trig), 32'(oh));
        if (chk_period) chk("slot_period", cyc - last_rise, SC);
        last_rise = cyc;
        n = 0;
        while (trig === oh && n < 4 * TC) begin tick(); n++; end
        chk("trig_width", n, TC);
        if (width == 0) begin
            n = 0;
            while (res_valid !== 1'b1 && n < 3 * WM) begin tick(); n++; end
            chk("noecho_latency", 32'(n >= WM - 1 && n <= WM + 1), 1);
        end else begin
            repeat (3) tick();
            echo = echo | nb;
            repeat (4) tick();
            echo = echo & ~nb;
            repeat (3) tick();
            echo = echo | oh;
            if (width > 0) begin
                for (int k = 0; k < width; k++) begin
                    if (k == drop_k) enable = 1'b0;
                    tick();
                end
                echo = echo & ~oh;
                n = 0;
                while (res_valid !== 1'b1 && n < 20) begin tick(); n++; end
                chk("fall_to_valid", n, 4);
            end else begin
                n = 0;
                while (res_valid !== 1'b1 && n < (MC + 3) * D) begin tick(); n++; end
                chk("range_latency", n, (MC + 1) * D + 4);
                echo = echo & ~oh;
            end
        end
        chk("res_sel",    32'(res_sel),    idx);
        chk("res_dist",   32'(res_dist),   exp_dist);
        chk("res_status", 32'(res_status), 32'(exp_st));
        chk("frame_done", 32'(frame_done), 32'(idx == N - 1));
        tick();
        chk("valid_strobe", 32'(res_valid), 0);
        chk("dist_hold",    32'(res_dist),  exp_dist);
    endtask

    initial begin : main
        int n;
        int nv;
        sys_rst = 1'b0;
        enable  = 1'b0;
        echo    = '0;
        repeat (2) tick();
        chk_reset_outputs("por");

        sys_rst = 1'b1;
        repeat (3) tick();
        chk("idle_trig", 32'(trig), 0);
        chk("idle_busy", 32'(busy), 0);

        enable = 1'b1;
        n = 0;
        while (trig !== 4'b0001 && n < 10) begin tick(); n++; end
        chk("enable_to_trig", n, 2);
        chk("busy_scan", 32'(busy), 1);

        // Frame A: normal, no echo, out of range, exact cm multiple.
        run_slot(0, 73,  -1, 7,  2'b00, 1'b0);
        run_slot(1, 0,   -1, 0,  2'b01, 1'b1);
        run_slot(2, -1,  -1, MC, 2'b10, 1'b1);
        run_slot(3, 50,  -1, 5,  2'b00, 1'b1);

        // Frame B: full frame, last slot at the largest reportable distance.
        run_slot(0, 19,  -1, 1,  2'b00, 1'b1);
        run_slot(1, 55,  -1, 5,  2'b00, 1'b1);
        run_slot(2, 129, -1, 12, 2'b00, 1'b1);
        run_slot(3, 209, -1, MC, 2'b00, 1'b1);

        // Frame C: fall coincident with overflow, then enable dropped mid-measure.
        run_slot(0, 210, -1, MC, 2'b10, 1'b1);
        run_slot(1, 60,  20, 6,  2'b00, 1'b1);
        n = 0;
        while (busy !== 1'b0 && n < 2 * SC) begin tick(); n++; end
        chk("guard_then_idle", cyc - last_rise, SC);
        repeat (20) tick();
        chk("stopped_trig", 32'(trig), 0);
        chk("stopped_busy", 32'(busy), 0);
        chk("result_count", n_valid, 10);
        chk("frame_count",  n_frame, 2);

        enable = 1'b1;
        n = 0;
        while (trig !== 4'b0100 && n < 10) begin tick(); n++; end
        chk("resume_sel2", n, 2);

        repeat (2) tick();
        sys_rst = 1'b0;
        #1;
        chk_reset_outputs("midtrig");
        nv = n_valid;
        repeat (3) tick();
        chk("held_trig", 32'(trig), 0);
        chk("held_busy", 32'(busy), 0);
        sys_rst = 1'b1;
        n = 0;
        while (trig !== 4'b0001 && n < 10) begin tick(); n++; end
        chk("restart_sel0", n, 2);
        chk("no_valid_on_reset", n_valid, nv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
